// File: rtl/mc_ctrl_pkg.sv
// ============================================================================
// mc_ctrl_pkg : shared encodings for the handshake multicycle control unit
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mc_ctrl_pkg;

   // JAL and JALR share one state (is_immediate follows the opcode) so the
   // full set, including the mul/div states, fits the 4-bit debug encoding.
   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_MEMADR   = 4'd2,
      ST_MEMREAD  = 4'd3,
      ST_MEMWB    = 4'd4,
      ST_MEMWRITE = 4'd5,
      ST_EXECUTER = 4'd6,
      ST_EXECUTEI = 4'd7,
      ST_JUMP     = 4'd8,
      ST_BRANCH   = 4'd9,
      ST_AUIPC    = 4'd10,
      ST_LUI      = 4'd11,
      ST_ALUWB    = 4'd12,
      ST_MULDIV   = 4'd13,
      ST_MDWB     = 4'd14,
      ST_TRAP     = 4'd15
   } state_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [1:0] ALUOP_ADD    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

   localparam logic [1:0] SRC_A_PC     = 2'b00;
   localparam logic [1:0] SRC_A_RS1    = 2'b01;
   localparam logic [1:0] SRC_A_OLDPC  = 2'b10;
   localparam logic [1:0] SRC_A_ZERO   = 2'b11;

   localparam logic [1:0] SRC_B_RS2    = 2'b00;
   localparam logic [1:0] SRC_B_FOUR   = 2'b01;
   localparam logic [1:0] SRC_B_IMM    = 2'b10;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_BUS     = 2'b10;

   function automatic logic is_mem_state(input state_e s);
      return (s == ST_FETCH) || (s == ST_MEMREAD) || (s == ST_MEMWRITE);
   endfunction

endpackage

`default_nettype wire

// File: rtl/mc_mem_wait_timer.sv
// ============================================================================
// mc_mem_wait_timer : per-access wait counter with bus-timeout strobe
// Revision          : 1.0
// ============================================================================
`default_nettype none

module mc_mem_wait_timer #(
   parameter int MEM_TIMEOUT = 16,
   parameter int TIMER_W     = 5
) (
   input  logic clk,
   input  logic rst_n,
   input  logic wait_cycle,
   output logic timeout
);

   logic [TIMER_W-1:0] count_q;
   logic [TIMER_W-1:0] count_d;

   generate
      if (MEM_TIMEOUT > 0) begin : g_timeout
         assign timeout = wait_cycle && (count_q == TIMER_W'(MEM_TIMEOUT - 1));
      end else begin : g_no_timeout
         assign timeout = 1'b0;
      end
   endgenerate

   // Any cycle that is not a held wait (ready, leaving, or outside a memory
   // state) zeroes the count, so every new access starts from 0.
   always_comb begin
      count_d = '0;
      if (wait_cycle && !timeout) begin
         count_d = count_q + TIMER_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mc_control_unit_hs.sv
// ============================================================================
// mc_control_unit_hs : RV32I multicycle control FSM with memory handshake,
//                      traps, and optional mul/div sequencing (MC_MULDIV_EN)
// Revision           : 1.0
// ============================================================================
`default_nettype none

module mc_control_unit_hs
   import mc_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int TIMER_W     = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] instruction_opcode,
   input  logic [6:0] instruction_funct7,
   input  logic       mem_ready,
   input  logic       md_done,
   output logic       pc_write,
   output logic       ir_write,
   output logic       pc_source,
   output logic       reg_write,
   output logic       memory_read,
   output logic       memory_write,
   output logic       is_immediate,
   output logic       pc_write_cond,
   output logic       lorD,
   output logic       memory_to_reg,
   output logic [1:0] aluop,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic       md_start,
   output logic       md_wb_sel,
   output logic       trap,
   output logic [1:0] trap_cause,
   output logic [3:0] dbg_state
);

   state_e     state_q, state_d;
   logic [1:0] cause_q, cause_d;
   logic       timeout;

`ifdef MC_MULDIV_EN
   logic md_issued_q, md_issued_d;
`else
   logic unused_md_done;
   assign unused_md_done = md_done;
`endif

   mc_mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .TIMER_W     (TIMER_W)
   ) u_wait_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .wait_cycle (is_mem_state(state_q) && !mem_ready),
      .timeout    (timeout)
   );

   always_comb begin
      state_d       = state_q;
      cause_d       = cause_q;
      pc_write      = 1'b0;
      ir_write      = 1'b0;
      pc_source     = 1'b0;
      reg_write     = 1'b0;
      memory_read   = 1'b0;
      memory_write  = 1'b0;
      is_immediate  = 1'b0;
      pc_write_cond = 1'b0;
      lorD          = 1'b0;
      memory_to_reg = 1'b0;
      aluop         = ALUOP_ADD;
      alu_src_a     = SRC_A_PC;
      alu_src_b     = SRC_B_RS2;
      md_start      = 1'b0;
      md_wb_sel     = 1'b0;
`ifdef MC_MULDIV_EN
      md_issued_d   = (state_q == ST_MULDIV);
`endif

      case (state_q)
         ST_FETCH: begin
            memory_read = !timeout;
            alu_src_b   = SRC_B_FOUR;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = ST_DECODE;
            end else if (timeout) begin
               state_d = ST_TRAP;
               cause_d = CAUSE_BUS;
            end
         end
         ST_DECODE: begin
            alu_src_a = SRC_A_OLDPC;
            alu_src_b = SRC_B_IMM;
            case (instruction_opcode)
               OP_LOAD, OP_STORE: state_d = ST_MEMADR;
               OP_RTYPE:          state_d = ST_EXECUTER;
               OP_ITYPE:          state_d = ST_EXECUTEI;
               OP_JAL, OP_JALR:   state_d = ST_JUMP;
               OP_BRANCH:         state_d = ST_BRANCH;
               OP_AUIPC:          state_d = ST_AUIPC;
               OP_LUI:            state_d = ST_LUI;
               default: begin
                  state_d = ST_TRAP;
                  cause_d = CAUSE_ILLEGAL;
               end
            endcase
         end
         ST_MEMADR: begin
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_IMM;
            state_d   = (instruction_opcode == OP_LOAD) ? ST_MEMREAD : ST_MEMWRITE;
         end
         ST_MEMREAD: begin
            memory_read = !timeout;
            lorD        = !timeout;
            if (mem_ready) begin
               state_d = ST_MEMWB;
            end else if (timeout) begin
               state_d = ST_TRAP;
               cause_d = CAUSE_BUS;
            end
         end
         ST_MEMWB: begin
            reg_write     = 1'b1;
            memory_to_reg = 1'b1;
            state_d       = ST_FETCH;
         end
         ST_MEMWRITE: begin
            memory_write = !timeout;
            lorD         = !timeout;
            if (mem_ready) begin
               state_d = ST_FETCH;
            end else if (timeout) begin
               state_d = ST_TRAP;
               cause_d = CAUSE_BUS;
            end
         end
         ST_EXECUTER: begin
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_RS2;
            aluop     = ALUOP_FUNCT;
            state_d   = ST_ALUWB;
            if (instruction_funct7 == F7_MULDIV) begin
`ifdef MC_MULDIV_EN
               state_d = ST_MULDIV;
`else
               state_d = ST_TRAP;
               cause_d = CAUSE_ILLEGAL;
`endif
            end
         end
         ST_EXECUTEI: begin
            alu_src_a    = SRC_A_RS1;
            alu_src_b    = SRC_B_IMM;
            aluop        = ALUOP_FUNCT;
            is_immediate = 1'b1;
            state_d      = ST_ALUWB;
         end
         ST_JUMP: begin
            alu_src_a    = SRC_A_OLDPC;
            alu_src_b    = SRC_B_FOUR;
            pc_write     = 1'b1;
            pc_source    = 1'b1;
            is_immediate = (instruction_opcode == OP_JALR);
            state_d      = ST_ALUWB;
         end
         ST_BRANCH: begin
            alu_src_a     = SRC_A_RS1;
            alu_src_b     = SRC_B_RS2;
            aluop         = ALUOP_BRANCH;
            pc_write_cond = 1'b1;
            pc_source     = 1'b1;
            state_d       = ST_FETCH;
         end
         ST_AUIPC: begin
            alu_src_a = SRC_A_OLDPC;
            alu_src_b = SRC_B_IMM;
            state_d   = ST_ALUWB;
         end
         ST_LUI: begin
            alu_src_a = SRC_A_ZERO;
            alu_src_b = SRC_B_IMM;
            state_d   = ST_ALUWB;
         end
         ST_ALUWB: begin
            reg_write = 1'b1;
            state_d   = ST_FETCH;
         end
`ifdef MC_MULDIV_EN
         ST_MULDIV: begin
            md_start = !md_issued_q;
            if (md_done) begin
               state_d = ST_MDWB;
            end
         end
         ST_MDWB: begin
            reg_write = 1'b1;
            md_wb_sel = 1'b1;
            state_d   = ST_FETCH;
         end
`endif
         ST_TRAP: begin
            state_d = ST_TRAP;
         end
         default: begin
            state_d = ST_TRAP;
            cause_d = CAUSE_ILLEGAL;
         end
      endcase
   end

   assign trap       = (state_q == ST_TRAP);
   assign trap_cause = cause_q;
   assign dbg_state  = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_FETCH;
         cause_q <= CAUSE_NONE;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
      end
   end

`ifdef MC_MULDIV_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         md_issued_q <= 1'b0;
      end else begin
         md_issued_q <= md_issued_d;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mc_control_unit_hs.sv
// ============================================================================
// tb_mc_control_unit_hs : instruction-level model check of mc_control_unit_hs
// Revision              : 1.0
// ============================================================================
`default_nettype none

module tb_mc_control_unit_hs;
   import mc_ctrl_pkg::*;

   localparam int TO = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] instruction_opcode = '0;
   logic [6:0] instruction_funct7 = '0;
   logic       mem_ready = 1'b0;
   logic       md_done = 1'b0;
   logic       pc_write, ir_write, pc_source, reg_write, memory_read, memory_write;
   logic       is_immediate, pc_write_cond, lorD, memory_to_reg, md_start, md_wb_sel, trap;
   logic [1:0] aluop, alu_src_a, alu_src_b, trap_cause;
   logic [3:0] dbg_state;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc_no = 0;

   always #5 clk = ~clk;

   mc_control_unit_hs #(.MEM_TIMEOUT(TO), .TIMER_W(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .instruction_opcode(instruction_opcode), .instruction_funct7(instruction_funct7),
      .mem_ready(mem_ready), .md_done(md_done),
      .pc_write(pc_write), .ir_write(ir_write), .pc_source(pc_source), .reg_write(reg_write),
      .memory_read(memory_read), .memory_write(memory_write), .is_immediate(is_immediate),
      .pc_write_cond(pc_write_cond), .lorD(lorD), .memory_to_reg(memory_to_reg),
      .aluop(aluop), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .md_start(md_start), .md_wb_sel(md_wb_sel), .trap(trap), .trap_cause(trap_cause),
      .dbg_state(dbg_state)
   );

   // Control vector layout used by the expected values below.
   localparam logic [18:0] PCW  = 19'd1 << 18;
   localparam logic [18:0] IRW  = 19'd1 << 17;
   localparam logic [18:0] PCS  = 19'd1 << 16;
   localparam logic [18:0] RW   = 19'd1 << 15;
   localparam logic [18:0] MR   = 19'd1 << 14;
   localparam logic [18:0] MW   = 19'd1 << 13;
   localparam logic [18:0] IMM  = 19'd1 << 12;
   localparam logic [18:0] PWC  = 19'd1 << 11;
   localparam logic [18:0] LORD = 19'd1 << 10;
   localparam logic [18:0] M2R  = 19'd1 << 9;
   localparam logic [18:0] MDS  = 19'd1 << 2;
   localparam logic [18:0] MDW  = 19'd1 << 1;
   localparam logic [18:0] TR   = 19'd1;

   logic [18:0] obs;
   assign obs = {pc_write, ir_write, pc_source, reg_write, memory_read, memory_write,
                 is_immediate, pc_write_cond, lorD, memory_to_reg, aluop, alu_src_a,
                 alu_src_b, md_start, md_wb_sel, trap};

   function automatic logic [18:0] f_aop(input int v); return 19'(v) << 7; endfunction
   function automatic logic [18:0] f_sa(input int v);  return 19'(v) << 5; endfunction
   function automatic logic [18:0] f_sb(input int v);  return 19'(v) << 3; endfunction
   function automatic logic rb(); return 1'($urandom_range(0, 1)); endfunction

   task automatic check(input string tag, input logic [3:0] est, input logic [18:0] ectl,
                        input logic [1:0] ecause);
      n_cmp++;
      assert (dbg_state === est) else begin
         n_bad++;
         $error("FAIL %s_state cyc=%0d got=%0d exp=%0d", tag, cyc_no, dbg_state, est);
      end
      n_cmp++;
      assert (obs === ectl) else begin
         n_bad++;
         $error("FAIL %s_ctl cyc=%0d got=%h exp=%h", tag, cyc_no, obs, ectl);
      end
      n_cmp++;
      assert (trap_cause === ecause) else begin
         n_bad++;
         $error("FAIL %s_cause cyc=%0d got=%0d exp=%0d", tag, cyc_no, trap_cause, ecause);
      end
   endtask

   // One clock cycle: apply inputs, let combinational outputs settle, compare.
   task automatic cyc(input logic rdy, input logic done, input logic [3:0] est,
                      input logic [18:0] ectl, input logic [1:0] ecause);
      @(negedge clk);
      mem_ready = rdy;
      md_done   = done;
      cyc_no++;
      #1;
      check("seq", est, ectl, ecause);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      mem_ready = 1'b0;
      #1;
      check("reset", ST_FETCH, MR | f_sb(1), CAUSE_NONE);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic trap_tail(input logic [1:0] cause);
      for (int i = 0; i < 10; i++) cyc(rb(), rb(), ST_TRAP, TR, cause);
      do_reset();
   endtask

   // A memory access waits nwait cycles then completes, unless the wait
   // budget of TO cycles runs out first.
   task automatic mem_phase(input logic [3:0] st, input logic [18:0] base, input int nwait,
                            input logic [18:0] go_extra, output bit timed_out);
      timed_out = 1'b0;
      for (int i = 0; i < TO; i++) begin
         if (i == nwait) begin
            cyc(1'b1, rb(), st, base | go_extra, CAUSE_NONE);
            break;
         end else if (i == TO - 1) begin
            cyc(1'b0, rb(), st, base & ~(MR | MW | LORD), CAUSE_NONE);
            timed_out = 1'b1;
            break;
         end else begin
            cyc(1'b0, rb(), st, base, CAUSE_NONE);
         end
      end
   endtask

   task automatic run_instr(input logic [6:0] op, input logic [6:0] f7, input int fw,
                            input int mw, input int mdl);
      bit to;
      instruction_opcode = op;
      instruction_funct7 = f7;
      mem_phase(ST_FETCH, MR | f_sb(1), fw, PCW | IRW, to);
      if (to) begin
         cyc(rb(), rb(), ST_TRAP, TR, CAUSE_BUS);
         trap_tail(CAUSE_BUS);
         return;
      end
      cyc(rb(), rb(), ST_DECODE, f_sa(2) | f_sb(2), CAUSE_NONE);
      case (op)
         OP_LOAD: begin
            cyc(rb(), rb(), ST_MEMADR, f_sa(1) | f_sb(2), CAUSE_NONE);
            mem_phase(ST_MEMREAD, MR | LORD, mw, '0, to);
            if (to) begin
               trap_tail(CAUSE_BUS);
               return;
            end
            cyc(rb(), rb(), ST_MEMWB, RW | M2R, CAUSE_NONE);
         end
         OP_STORE: begin
            cyc(rb(), rb(), ST_MEMADR, f_sa(1) | f_sb(2), CAUSE_NONE);
            mem_phase(ST_MEMWRITE, MW | LORD, mw, '0, to);
            if (to) begin
               trap_tail(CAUSE_BUS);
               return;
            end
         end
         OP_RTYPE: begin
            cyc(rb(), rb(), ST_EXECUTER, f_sa(1) | f_sb(0) | f_aop(2), CAUSE_NONE);
            if (f7 == F7_MULDIV) begin
`ifdef MC_MULDIV_EN
               for (int i = 0; i <= mdl; i++)
                  cyc(rb(), (i == mdl), ST_MULDIV, (i == 0) ? MDS : '0, CAUSE_NONE);
               cyc(rb(), rb(), ST_MDWB, RW | MDW, CAUSE_NONE);
`else
               trap_tail(CAUSE_ILLEGAL);
               return;
`endif
            end else begin
               cyc(rb(), rb(), ST_ALUWB, RW, CAUSE_NONE);
            end
         end
         OP_ITYPE: begin
            cyc(rb(), rb(), ST_EXECUTEI, f_sa(1) | f_sb(2) | f_aop(2) | IMM, CAUSE_NONE);
            cyc(rb(), rb(), ST_ALUWB, RW, CAUSE_NONE);
         end
         OP_JAL, OP_JALR: begin
            cyc(rb(), rb(), ST_JUMP,
                f_sa(2) | f_sb(1) | PCW | PCS | ((op == OP_JALR) ? IMM : '0), CAUSE_NONE);
            cyc(rb(), rb(), ST_ALUWB, RW, CAUSE_NONE);
         end
         OP_BRANCH: begin
            cyc(rb(), rb(), ST_BRANCH, f_sa(1) | f_sb(0) | f_aop(1) | PWC | PCS, CAUSE_NONE);
         end
         OP_AUIPC: begin
            cyc(rb(), rb(), ST_AUIPC, f_sa(2) | f_sb(2), CAUSE_NONE);
            cyc(rb(), rb(), ST_ALUWB, RW, CAUSE_NONE);
         end
         OP_LUI: begin
            cyc(rb(), rb(), ST_LUI, f_sa(3) | f_sb(2), CAUSE_NONE);
            cyc(rb(), rb(), ST_ALUWB, RW, CAUSE_NONE);
         end
         default: begin
            trap_tail(CAUSE_ILLEGAL);
         end
      endcase
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0] ops [10];
      logic [6:0] f7s [3];
      ops = '{OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL,
              OP_JALR, OP_BRANCH, OP_AUIPC, OP_LUI, 7'b1111111};
      f7s = '{7'b0000000, 7'b0100000, F7_MULDIV};

      do_reset();

      // Load with 3 fetch waits and 2 read waits.
      run_instr(OP_LOAD, 7'd0, 3, 2, 0);
      // Illegal opcode traps and stays trapped until reset.
      run_instr(7'b1111111, 7'd0, 0, 0, 0);
      // Fetch times out after exactly TO cycles; ready on the last one wins.
      run_instr(OP_LUI, 7'd0, TO, 0, 0);
      run_instr(OP_LUI, 7'd0, TO - 1, 0, 0);
      // Branch, mul/div, and a read timeout.
      run_instr(OP_BRANCH, 7'd0, 0, 0, 0);
      run_instr(OP_RTYPE, F7_MULDIV, 0, 0, 5);
      run_instr(OP_LOAD, 7'd0, 1, TO, 0);

      // Reset asserted while a store is waiting drops memory_write at once.
      instruction_opcode = OP_STORE;
      instruction_funct7 = 7'd0;
      cyc(1'b1, 1'b0, ST_FETCH, MR | f_sb(1) | PCW | IRW, CAUSE_NONE);
      cyc(1'b0, 1'b0, ST_DECODE, f_sa(2) | f_sb(2), CAUSE_NONE);
      cyc(1'b0, 1'b0, ST_MEMADR, f_sa(1) | f_sb(2), CAUSE_NONE);
      cyc(1'b0, 1'b0, ST_MEMWRITE, MW | LORD, CAUSE_NONE);
      do_reset();
      run_instr(OP_ITYPE, 7'd0, TO - 1, 0, 0);

      for (int n = 0; n < 60; n++) begin
         logic [6:0] op;
         int         fw, mw;
         op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
         fw = ($urandom_range(0, 7) == 0) ? $urandom_range(TO, TO + 2) : $urandom_range(0, TO - 1);
         mw = ($urandom_range(0, 7) == 0) ? $urandom_range(TO, TO + 2) : $urandom_range(0, TO - 1);
         run_instr(op, f7s[$urandom_range(0, 2)], fw, mw, $urandom_range(0, 5));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mc_control_unit_hs.md
Name: mc_control_unit_hs

Overview:
Multicycle RV32I control FSM with a variable-latency memory handshake. It drives the same datapath select/enable signals as the existing single-latency control unit, but also does the following:
- waits on mem_ready for every memory access;
- traps on an illegal opcode or a memory timeout;
- optionally sequences a multi-cycle MUL/DIV unit.

It sits between the instruction register/opcode decode and the multicycle datapath muxes.

Parameters:
MEM_TIMEOUT, 16, max wait cycles per memory access before a bus-error trap; 0 = no timeout
TIMER_W, 5, width of the wait counter; must hold MEM_TIMEOUT

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
instruction_opcode  in  7  opcode field of IR
instruction_funct7  in  7  funct7 field of IR
mem_ready  in  1  memory completes current read/write this cycle
md_done  in  1  mul/div result valid (one-cycle pulse)
pc_write, ir_write, pc_source, reg_write, memory_read, memory_write, is_immediate, pc_write_cond, lorD, memory_to_reg  out  1 each  datapath controls
aluop  out  2  00 add, 01 branch compare, 10 funct-decoded
alu_src_a  out  2  00 PC, 01 rs1, 10 old PC, 11 zero
alu_src_b  out  2  00 rs2, 01 const 4, 10 imm
md_start  out  1  one-cycle start pulse to mul/div unit
md_wb_sel  out  1  write-back source is mul/div result
trap  out  1  sticky; core halted
trap_cause  out  2  00 none, 01 illegal instruction, 10 bus timeout
dbg_state  out  4  current state encoding

Behaviour:
- State register and wait counter reset asynchronously.
- Reset values: state FETCH, counter 0, trap 0, cause 00.
- All other outputs are combinational from state and inputs. Any output not listed for a state is 0.
- FETCH: memory_read=1, alu_src_b=01.
  - If mem_ready=1: ir_write=1, pc_write=1, go to DECODE.
  - Otherwise stay in FETCH; ir_write and pc_write stay 0.
- DECODE: alu_src_a=10, alu_src_b=10. Dispatch on opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1101111 → JAL
  - 1100111 → JALR
  - 1100011 → BRANCH
  - 0010111 → AUIPC
  - 0110111 → LUI
  - anything else → TRAP with cause 01
- MEMADR: alu_src_a=01, alu_src_b=10. LW → MEMREAD; SW → MEMWRITE.
- MEMREAD: memory_read=1, lorD=1. On mem_ready go to MEMWB.
- MEMWB: reg_write=1, memory_to_reg=1, then FETCH.
- MEMWRITE: memory_write=1, lorD=1. On mem_ready go to FETCH.
- EXECUTER: alu_src_a=01, alu_src_b=00, aluop=10, then ALUWB. funct7=0000001 is handled per Optional Feature.
- EXECUTEI: alu_src_a=01, alu_src_b=10, aluop=10, is_immediate=1, then ALUWB.
- JAL: alu_src_a=10, alu_src_b=01, pc_write=1, pc_source=1, then ALUWB.
- JALR: same as JAL plus is_immediate=1, then ALUWB.
- BRANCH: alu_src_a=01, alu_src_b=00, aluop=01, pc_write_cond=1, pc_source=1, then FETCH.
- AUIPC: alu_src_a=10, alu_src_b=10, then ALUWB.
- LUI: alu_src_a=11, alu_src_b=10, then ALUWB.
- ALUWB: reg_write=1, then FETCH.
- TRAP: all datapath enables 0, trap=1. Absorbing state; only rst_n exits.
- Wait counter and timeout:
  - The counter clears on entry to FETCH, MEMREAD or MEMWRITE.
  - It increments each cycle that state is held with mem_ready=0.
  - If MEM_TIMEOUT>0 and the counter equals MEM_TIMEOUT-1 with mem_ready=0, go to TRAP with cause 10. No enable fires in that cycle.
  - mem_ready=1 on the boundary cycle wins over the timeout.
- Reset mid-access drops memory_read/memory_write immediately (combinational from state).
- mem_ready outside memory states is ignored.

Optional Feature:
Macro MC_MULDIV_EN.
- With the macro: EXECUTER with funct7=0000001 goes to MULDIV instead of ALUWB.
  - First cycle in MULDIV: md_start=1 (pulse once per instruction).
  - Stay in MULDIV until md_done=1, then go to MDWB.
  - MDWB: reg_write=1, md_wb_sel=1, then FETCH.
  - MULDIV has no timeout.
- Without the macro: funct7=0000001 in EXECUTER goes to TRAP with cause 01. md_start and md_wb_sel are tied 0. MULDIV and MDWB are not implemented.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state localparams (4-bit);
  - opcode constants;
  - aluop, src_a and src_b encodings;
  - trap_cause codes.
- One sub-module, mc_mem_wait_timer: counter, clear-on-entry and timeout compare. It is parametrised by MEM_TIMEOUT/TIMER_W and outputs a timeout strobe.

Test Plan:
- LW with mem_ready low 3 cycles in FETCH and 2 in MEMREAD → states FETCH×4, DECODE, MEMADR, MEMREAD×3, MEMWB, FETCH. ir_write=1 only in the 4th FETCH cycle; reg_write=1 in MEMWB only.
- Opcode 1111111 → DECODE then TRAP. trap=1, trap_cause=01, all enables 0 for 10 cycles until rst_n pulse returns to FETCH.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH → TRAP after exactly 4 FETCH cycles, cause 10. Repeat with mem_ready=1 on the 4th cycle → DECODE, no trap.
- BEQ (1100011) with ready=1 → FETCH, DECODE, BRANCH (pc_write_cond=1, aluop=01, pc_source=1), FETCH: 3 cycles total.
- R-type funct7=0000001, md_done after 5 cycles. With MC_MULDIV_EN: md_start high 1 cycle, MDWB reg_write=1 with md_wb_sel=1. Without the macro: TRAP with cause 01.
- Assert rst_n low during MEMWRITE wait → memory_write drops that same cycle; after release, state FETCH and counter 0.
